// File: rtl/stall_ctrl_defs.sv
// Shared constants for the stall controller: channel state encoding and default timeout sizing.
package stall_ctrl_defs;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } ch_state_e;

    localparam int unsigned DefTimeoutW   = 8;
    localparam int unsigned DefTimeoutMax = 255;

endpackage

// File: rtl/stall_channel.sv
// One req/ack handshake channel: holds its phase's stall until ack or timeout.
module stall_channel
    import stall_ctrl_defs::*;
#(
    parameter int unsigned TIMEOUT_W   = DefTimeoutW,
    parameter int unsigned TIMEOUT_MAX = DefTimeoutMax
) (
    input  logic clk,
    input  logic rst,
    input  logic phase,
    input  logic need,
    input  logic ack,
    output logic req,
    output logic stall,
    output logic timeout
);

    ch_state_e            state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 stall_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout   = 1'b0;
        stall_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_raw = phase & need;
                if (phase) begin
                    if (need) begin
                        state_d = StReq;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StReq: begin
                stall_raw = phase;
                // A phase that vanishes mid-handshake aborts quietly, never as a timeout.
                if (!phase) begin
                    state_d = StIdle;
                end else if (ack) begin
                    state_d = StDone;
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT_MAX)) begin
                    state_d = StDone;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            StDone: begin
                if (!phase) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req   = (state_q == StReq);
    // Outputs must read 0 while reset is held, even with a phase already high.
    assign stall = stall_raw & ~rst;

endmodule

// File: rtl/stall_controller.sv
// Generates stall_* for the core phase FSM from three handshake channels plus sticky error flags.
module stall_controller
    import stall_ctrl_defs::*;
#(
    parameter int unsigned TIMEOUT_W   = DefTimeoutW,
    parameter int unsigned TIMEOUT_MAX = DefTimeoutMax
) (
    input  logic clk,
    input  logic rst,
    input  logic phase_fetch,
    input  logic phase_decode,
    input  logic phase_execute,
    input  logic phase_memoryaccess,
    input  logic phase_writeback,
    input  logic ex_multicycle,
    input  logic mem_access,
    input  logic imem_ack,
    input  logic ex_done,
    input  logic dmem_ack,
    output logic imem_req,
    output logic ex_start,
    output logic dmem_req,
    output logic stall_fetch,
    output logic stall_decode,
    output logic stall_execute,
    output logic stall_memoryaccess,
    output logic stall_writeback,
    output logic bus_timeout,
    output logic phase_error
);

    logic [2:0] timeout;
    logic [2:0] phase_cnt;
    logic       bus_timeout_q;
    logic       phase_error_q;

    stall_channel #(
        .TIMEOUT_W  (TIMEOUT_W),
        .TIMEOUT_MAX(TIMEOUT_MAX)
    ) u_fetch (
        .clk    (clk),
        .rst    (rst),
        .phase  (phase_fetch),
        .need   (1'b1),
        .ack    (imem_ack),
        .req    (imem_req),
        .stall  (stall_fetch),
        .timeout(timeout[0])
    );

    stall_channel #(
        .TIMEOUT_W  (TIMEOUT_W),
        .TIMEOUT_MAX(TIMEOUT_MAX)
    ) u_execute (
        .clk    (clk),
        .rst    (rst),
        .phase  (phase_execute),
        .need   (ex_multicycle),
        .ack    (ex_done),
        .req    (ex_start),
        .stall  (stall_execute),
        .timeout(timeout[1])
    );

    stall_channel #(
        .TIMEOUT_W  (TIMEOUT_W),
        .TIMEOUT_MAX(TIMEOUT_MAX)
    ) u_memory (
        .clk    (clk),
        .rst    (rst),
        .phase  (phase_memoryaccess),
        .need   (mem_access),
        .ack    (dmem_ack),
        .req    (dmem_req),
        .stall  (stall_memoryaccess),
        .timeout(timeout[2])
    );

    assign phase_cnt = 3'(phase_fetch) + 3'(phase_decode) + 3'(phase_execute)
                     + 3'(phase_memoryaccess) + 3'(phase_writeback);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_timeout_q <= 1'b0;
            phase_error_q <= 1'b0;
        end else begin
            if (|timeout) begin
                bus_timeout_q <= 1'b1;
            end
            if (phase_cnt > 3'd1) begin
                phase_error_q <= 1'b1;
            end
        end
    end

    assign bus_timeout     = bus_timeout_q;
    assign phase_error     = phase_error_q;
    assign stall_decode    = 1'b0;
    assign stall_writeback = 1'b0;

endmodule

// File: tb/tb_stall_controller.sv
// Self-checking bench: directed handshake scenarios plus randomized phases against a handshake model.
module tb_stall_controller;

    localparam int unsigned TW = 3;
    localparam int unsigned TM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic phase_fetch = 1'b0, phase_decode = 1'b0, phase_execute = 1'b0;
    logic phase_memoryaccess = 1'b0, phase_writeback = 1'b0;
    logic ex_multicycle = 1'b0, mem_access = 1'b0;
    logic imem_ack = 1'b0, ex_done = 1'b0, dmem_ack = 1'b0;
    logic imem_req, ex_start, dmem_req;
    logic stall_fetch, stall_decode, stall_execute, stall_memoryaccess, stall_writeback;
    logic bus_timeout, phase_error;

    stall_controller #(
        .TIMEOUT_W  (TW),
        .TIMEOUT_MAX(TM)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .phase_fetch       (phase_fetch),
        .phase_decode      (phase_decode),
        .phase_execute     (phase_execute),
        .phase_memoryaccess(phase_memoryaccess),
        .phase_writeback   (phase_writeback),
        .ex_multicycle     (ex_multicycle),
        .mem_access        (mem_access),
        .imem_ack          (imem_ack),
        .ex_done           (ex_done),
        .dmem_ack          (dmem_ack),
        .imem_req          (imem_req),
        .ex_start          (ex_start),
        .dmem_req          (dmem_req),
        .stall_fetch       (stall_fetch),
        .stall_decode      (stall_decode),
        .stall_execute     (stall_execute),
        .stall_memoryaccess(stall_memoryaccess),
        .stall_writeback   (stall_writeback),
        .bus_timeout       (bus_timeout),
        .phase_error       (phase_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake model: per channel, is a request outstanding, how long has it waited,
    // and has the current phase already been served.
    logic [2:0] c_phase, c_need, c_ack;
    assign c_phase = {phase_memoryaccess, phase_execute, phase_fetch};
    assign c_need  = {mem_access, ex_multicycle, 1'b1};
    assign c_ack   = {dmem_ack, ex_done, imem_ack};

    bit m_busy[3];
    bit m_served[3];
    int m_waited[3];
    bit m_timeout, m_perr, m_valid;

    always @(posedge clk) begin
        if (rst) begin
            m_valid   = 1'b1;
            m_timeout = 1'b0;
            m_perr    = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_busy[i]   = 1'b0;
                m_served[i] = 1'b0;
                m_waited[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_busy[i]) begin
                    if (!c_phase[i]) begin
                        m_busy[i] = 1'b0;
                    end else if (c_ack[i]) begin
                        m_busy[i]   = 1'b0;
                        m_served[i] = 1'b1;
                    end else if (m_waited[i] == int'(TM)) begin
                        m_busy[i]   = 1'b0;
                        m_served[i] = 1'b1;
                        m_timeout   = 1'b1;
                    end else begin
                        m_waited[i]++;
                    end
                end else if (m_served[i]) begin
                    if (!c_phase[i]) m_served[i] = 1'b0;
                end else if (c_phase[i]) begin
                    if (c_need[i]) begin
                        m_busy[i]   = 1'b1;
                        m_waited[i] = 0;
                    end else begin
                        m_served[i] = 1'b1;
                    end
                end
            end
            if ($countones({phase_fetch, phase_decode, phase_execute,
                            phase_memoryaccess, phase_writeback}) > 1) begin
                m_perr = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [2:0] exp_stall;
            for (int i = 0; i < 3; i++) begin
                exp_stall[i] = !rst && c_phase[i] && (m_busy[i] || (!m_served[i] && c_need[i]));
            end
            check("imem_req", imem_req, m_busy[0]);
            check("ex_start", ex_start, m_busy[1]);
            check("dmem_req", dmem_req, m_busy[2]);
            check("stall_fetch", stall_fetch, exp_stall[0]);
            check("stall_execute", stall_execute, exp_stall[1]);
            check("stall_memoryaccess", stall_memoryaccess, exp_stall[2]);
            check("stall_decode", stall_decode, 1'b0);
            check("stall_writeback", stall_writeback, 1'b0);
            check("bus_timeout", bus_timeout, m_timeout);
            check("phase_error", phase_error, m_perr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        @(negedge clk);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_bus_timeout", bus_timeout, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Fetch: ack in cycle 3.
        for (int c = 0; c <= 5; c++) begin
            phase_fetch = (c <= 4);
            imem_ack    = (c == 3);
            @(negedge clk);
            if (c <= 4) begin
                check("fetch_req", imem_req, (c >= 1 && c <= 3));
                check("fetch_stall", stall_fetch, (c <= 3));
            end
            step();
        end
        imem_ack = 1'b0;

        // Execute without multi-cycle need.
        phase_execute = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("ex_single_stall", stall_execute, 1'b0);
            check("ex_single_start", ex_start, 1'b0);
            step();
        end
        phase_execute = 1'b0;
        step();

        // Execute multi-cycle, ex_done in cycle 5.
        ex_multicycle = 1'b1;
        phase_execute = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            ex_done = (c == 5);
            @(negedge clk);
            check("ex_multi_start", ex_start, (c >= 1 && c <= 5));
            check("ex_multi_stall", stall_execute, (c <= 5));
            step();
        end
        ex_done       = 1'b0;
        phase_execute = 1'b0;
        ex_multicycle = 1'b0;
        step();

        // Memory access with no ack: forced completion after TM+1 request cycles.
        phase_memoryaccess = 1'b1;
        mem_access         = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            check("to_dmem_req", dmem_req, (c >= 1 && c <= 5));
            check("to_stall", stall_memoryaccess, (c <= 5));
            check("to_bus_timeout", bus_timeout, (c >= 6));
            step();
        end
        phase_memoryaccess = 1'b0;
        mem_access         = 1'b0;
        step();
        @(negedge clk);
        check("to_sticky", bus_timeout, 1'b1);

        // Two phases at once.
        step();
        phase_fetch   = 1'b1;
        phase_execute = 1'b1;
        @(negedge clk);
        check("perr_c0", phase_error, 1'b0);
        step();
        phase_fetch   = 1'b0;
        phase_execute = 1'b0;
        @(negedge clk);
        check("perr_c1", phase_error, 1'b1);
        step();
        step();
        @(negedge clk);
        check("perr_sticky", phase_error, 1'b1);
        step();

        // Decode then writeback, 10 cycles each.
        for (int c = 0; c < 20; c++) begin
            phase_decode    = (c < 10);
            phase_writeback = (c >= 10);
            @(negedge clk);
            check("dw_stalls", stall_decode | stall_writeback, 1'b0);
            check("dw_reqs", imem_req | ex_start | dmem_req, 1'b0);
            step();
        end
        phase_writeback = 1'b0;
        step();

        // Reset in the middle of a fetch handshake, with a late ack.
        phase_fetch = 1'b1;
        step();
        step();
        @(negedge clk);
        check("mid_req_before", imem_req, 1'b1);
        rst      = 1'b1;
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_req_after", imem_req, 1'b0);
        check("mid_stall", stall_fetch, 1'b0);
        check("mid_bus_timeout", bus_timeout, 1'b0);
        check("mid_phase_error", phase_error, 1'b0);
        rst         = 1'b0;
        phase_fetch = 1'b0;
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        check("mid_late_ack", imem_req, 1'b0);
        step();

        // Randomized phases, needs, acks and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                int unsigned r;
                logic [4:0]  ph;
                r  = $urandom_range(0, 9);
                ph = (r <= 4) ? 5'(1 << r) : (r == 5) ? 5'd0 : 5'($urandom);
                {phase_writeback, phase_memoryaccess, phase_execute,
                 phase_decode, phase_fetch} = ph;
                ex_multicycle = 1'($urandom);
                mem_access    = 1'($urandom);
            end
            imem_ack = ($urandom_range(0, 3) == 0);
            ex_done  = ($urandom_range(0, 3) == 0);
            dmem_ack = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            step();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stall_controller.md
Name: stall_controller

Overview:
- Generates the stall_* inputs consumed by the core's phase state machine.
- Watches the five one-hot phase_* outputs of that state machine.
- On entry to fetch, execute or memoryaccess, it runs a req/ack handshake with the instruction memory, the multi-cycle execute unit or the data memory.
- It holds the matching stall until the handshake completes or times out.

Parameters:
TIMEOUT_W, 8, width of the per-channel wait counter
TIMEOUT_MAX, 255, last counted wait cycle before forced completion (must be ≤ 2^TIMEOUT_W-1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
phase_fetch  in  1  fetch phase active
phase_decode  in  1  decode phase active
phase_execute  in  1  execute phase active
phase_memoryaccess  in  1  memoryaccess phase active
phase_writeback  in  1  writeback phase active
ex_multicycle  in  1  current instruction needs the multi-cycle unit; sampled during execute
mem_access  in  1  current instruction is load/store; sampled during memoryaccess
imem_ack  in  1  instruction memory done
ex_done  in  1  multi-cycle unit done
dmem_ack  in  1  data memory done
imem_req  out  1  instruction fetch request
ex_start  out  1  multi-cycle unit request
dmem_req  out  1  data memory request
stall_fetch  out  1  hold fetch
stall_decode  out  1  hold decode
stall_execute  out  1  hold execute
stall_memoryaccess  out  1  hold memoryaccess
stall_writeback  out  1  hold writeback
bus_timeout  out  1  sticky: some channel timed out
phase_error  out  1  sticky: more than one phase_* high in a cycle

Behaviour:
- Reset: one clock domain (clk), reset synchronous and active-high (rst). While rst=1 at a clk edge, all channel states go to IDLE, counters to 0, both sticky flags to 0. Every output reads 0 during and after reset until a phase rises.
- Three identical channels, each with its own FSM, counter and need input:
  - Fetch: phase_fetch, imem_req/imem_ack, need = 1.
  - Execute: phase_execute, ex_start/ex_done, need = ex_multicycle.
  - Memory: phase_memoryaccess, dmem_req/dmem_ack, need = mem_access.
- Channel FSM (states IDLE, REQ, DONE):
  - IDLE: if phase=1 and need=1, go to REQ with cnt←0. If phase=1 and need=0, go to DONE. If phase=0, stay.
  - REQ: if ack=1, go to DONE. Else if cnt==TIMEOUT_MAX, go to DONE and set bus_timeout. Else cnt←cnt+1.
  - DONE: if phase=0, go to IDLE; else stay.
- req output = (state==REQ). It is a registered state decode with no combinational path from ack. ack is ignored in IDLE and DONE.
- stall output is combinational from phase, need and state only:
  - IDLE: phase & need.
  - REQ: phase.
  - DONE: 0.
- Latency: phase rises in cycle n, req is high from n+1, ack is seen in cycle n+k. State is DONE in n+k+1, so stall is 0 from cycle n+k+1. Minimum stalled cycles = 2, when ack arrives in n+1.
- Timeout: REQ lasts at most TIMEOUT_MAX+1 cycles. The phase then proceeds; bus_timeout stays 1 until rst.
- Phase drops while in REQ (illegal): go to IDLE next edge, drop req, do not set bus_timeout.
- stall_decode and stall_writeback are constant 0.
- phase_error is set in any cycle where the popcount of the five phase_* inputs exceeds 1. It stays 1 until rst.
- Channels are independent, so overlapping illegal phases still evaluate each channel normally.
- Reset mid-handshake: req drops at the first clk edge with rst=1. Any late ack is ignored.

Decomposition:
- Shared constants header stall_ctrl_defs: channel state encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and the default TIMEOUT_W/TIMEOUT_MAX.
- One sub-module, stall_channel (FSM, counter, req, stall, timeout pulse), instantiated three times.
- Top level adds the phase popcount, the sticky flags and the constant stall outputs.

Test Plan:
- Reset, then phase_fetch=1 at cycle 0 and imem_ack=1 at cycle 3 → imem_req=1 in cycles 1–3; stall_fetch=1 in cycles 0–3, 0 at cycle 4.
- phase_execute=1 with ex_multicycle=0 → stall_execute=0 in every cycle and ex_start never asserts; repeat with ex_multicycle=1 and ex_done at cycle 5 → ex_start=1 in cycles 1–5, stall_execute 0 from cycle 6.
- phase_memoryaccess=1, mem_access=1, dmem_ack never asserted, TIMEOUT_MAX=4 → dmem_req=1 for exactly 5 cycles, stall_memoryaccess drops at cycle 6, bus_timeout=1 and stays 1.
- rst=1 while imem_req=1, then imem_ack=1 → imem_req=0 the cycle after rst, all stalls 0, flags cleared; the ack causes no state change.
- phase_fetch=1 and phase_execute=1 in the same cycle → phase_error=1 sticky until rst.
- phase_decode=1 or phase_writeback=1 for 10 cycles → stall_decode=stall_writeback=0 throughout, no req outputs.
